// File: rtl/serial_cascade_comparator.sv
// Multi-cycle WIDTH-bit unsigned magnitude comparator, one 3-bit slice per clock.
// Optional build macro SERIAL_CMP_MSB_FIRST_EN: MSB-first walk with early termination.
module serial_cascade_comparator #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             et,
   output logic             gt
);

   localparam int unsigned NSLICE = WIDTH / 3;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   // Cascade encoding is {l,e,g}
   localparam logic [2:0] CASC_LT = 3'b100;
   localparam logic [2:0] CASC_EQ = 3'b010;
   localparam logic [2:0] CASC_GT = 3'b001;

`ifdef SERIAL_CMP_MSB_FIRST_EN
   localparam logic [IDX_W-1:0] START_IDX = LAST_IDX;
`else
   localparam logic [IDX_W-1:0] START_IDX = '0;
`endif

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op_a, op_a_nxt;
   logic [WIDTH-1:0] op_b, op_b_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [2:0]       casc, casc_nxt;
   logic [2:0]       res, res_nxt;
   logic             busy_nxt, done_nxt;

   logic [2:0]       slice_a, slice_b;
   logic             slice_gt, slice_lt;
   logic [2:0]       casc_upd;
   logic             finish;

   // Select the slice currently addressed by idx
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (idx == IDX_W'(i)) begin
            slice_a = op_a[3*i +: 3];
            slice_b = op_b[3*i +: 3];
         end
      end
   end

   assign slice_gt = (slice_a > slice_b);
   assign slice_lt = (slice_a < slice_b);

   // An unequal slice overrides; an equal slice inherits the carried result
   always_comb begin
      casc_upd = casc;
      if (slice_gt)
         casc_upd = CASC_GT;
      else if (slice_lt)
         casc_upd = CASC_LT;
   end

`ifdef SERIAL_CMP_MSB_FIRST_EN
   // From the top down, the first unequal slice settles the answer
   assign finish = slice_gt || slice_lt || (idx == '0);
`else
   assign finish = (idx == LAST_IDX);
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      op_a_nxt  = op_a;
      op_b_nxt  = op_b;
      idx_nxt   = idx;
      casc_nxt  = casc;
      res_nxt   = res;
      busy_nxt  = busy;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               op_a_nxt  = a;
               op_b_nxt  = b;
               casc_nxt  = CASC_EQ;
               idx_nxt   = START_IDX;
               busy_nxt  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            casc_nxt = casc_upd;
            if (finish) begin
               res_nxt   = casc_upd;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               idx_nxt   = '0;
               state_nxt = IDLE;
            end else begin
`ifdef SERIAL_CMP_MSB_FIRST_EN
               idx_nxt = idx - IDX_W'(1);
`else
               idx_nxt = idx + IDX_W'(1);
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            idx_nxt   = '0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_a  <= '0;
         op_b  <= '0;
         idx   <= '0;
         casc  <= CASC_EQ;
         res   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         op_a  <= op_a_nxt;
         op_b  <= op_b_nxt;
         idx   <= idx_nxt;
         casc  <= casc_nxt;
         res   <= res_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   assign lt = res[2];
   assign et = res[1];
   assign gt = res[0];

endmodule

// File: tb/tb_serial_cascade_comparator.sv
// Self-checking bench for serial_cascade_comparator: arithmetic reference model
// checked every cycle, plus directed vectors with literal results and latencies.
module tb_serial_cascade_comparator;

   localparam int unsigned WIDTH  = 12;
   localparam int unsigned NSLICE = WIDTH / 3;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, lt, et, gt;

   int n_cmp = 0;
   int n_bad = 0;

   serial_cascade_comparator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .lt    (lt),
      .et    (et),
      .gt    (gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference answer {lt,et,gt} from plain unsigned arithmetic
   function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      if (x < y) return 3'b100;
      if (x > y) return 3'b001;
      return 3'b010;
   endfunction

   // Cycles from accept to done
   function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SERIAL_CMP_MSB_FIRST_EN
      for (int k = 1; k <= int'(NSLICE); k++) begin
         int sh;
         sh = 3 * (int'(NSLICE) - k);
         if (((x >> sh) & 7) != ((y >> sh) & 7)) return k;
      end
      return int'(NSLICE);
`else
      return (x == y) ? int'(NSLICE) : int'(NSLICE);
`endif
   endfunction

   // Transaction-level model: accept when idle, finish after ref_lat cycles
   logic       m_busy, m_done;
   logic [2:0] m_res, m_pend;
   int         m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= 3'b000;
         m_pend <= 3'b000;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_pend <= ref_res(a, b);
               m_left <= ref_lat(a, b);
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_res  <= m_pend;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'({lt, et, gt}), 32'(m_res));
   end

   task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      @(negedge clk);
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = ~x;
      b     = ~y;
   endtask

   task automatic wait_done(input string name, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_cmp(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [2:0] exp_res, input int exp_lat);
      int cyc;
      issue(x, y);
      wait_done(name, cyc);
      chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_res"}, 32'({lt, et, gt}), 32'(exp_res));
      @(posedge clk);
      #1;
      chk({name, "_done_pulse"}, 32'(done), 32'd0);
   endtask

`ifdef SERIAL_CMP_MSB_FIRST_EN
   localparam int L_7000 = 1;
   localparam int L_0001 = 4;
   localparam int L_0100 = 4;
   localparam int L_0477 = 2;
`else
   localparam int L_7000 = 4;
   localparam int L_0001 = 4;
   localparam int L_0100 = 4;
   localparam int L_0477 = 4;
`endif

   initial begin
      int  cyc;
      bit  stray;
      rst_n = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_outs", 32'({busy, done, lt, et, gt}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Equal operands
      run_cmp("eq_zero", 12'o0000, 12'o0000, 3'b010, 4);
      run_cmp("eq_5252", 12'o5252, 12'o5252, 3'b010, 4);
      // Low and middle slices decide
      run_cmp("lsb_gt", 12'o0001, 12'o0000, 3'b001, L_0001);
      run_cmp("mid_lt", 12'o0100, 12'o0107, 3'b100, L_0100);
      run_cmp("mid_eq", 12'o0020, 12'o0020, 3'b010, 4);
      // Higher slice overrides lower ones
      run_cmp("hi_gt", 12'o7000, 12'o0777, 3'b001, L_7000);
      run_cmp("hi_lt", 12'o0477, 12'o0500, 3'b100, L_0477);
      run_cmp("msb_lt", 12'o1234, 12'o1235, 3'b100, 4);

      // Start while busy is ignored; start in done cycle is accepted
      issue(12'o1234, 12'o1235);
      @(posedge clk);
      #1;
      start = 1'b1;
      a     = 12'o7777;
      b     = 12'o0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start", cyc);
      chk("busy_start_lat", 32'(cyc + 2), 32'd4);
      chk("busy_start_res", 32'({lt, et, gt}), 32'(3'b100));
      start = 1'b1;
      a     = 12'o7000;
      b     = 12'o0777;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_busy", 32'(busy | done), 32'd1);
      cyc = (done) ? 1 : 0;
      for (int i = 0; i < 20 && !done; i++) begin
         chk("hold_res", 32'({lt, et, gt}), 32'(3'b100));
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("b2b_lat", 32'(cyc), 32'(L_7000));
      chk("b2b_res", 32'({lt, et, gt}), 32'(3'b001));

      // Asynchronous reset during the second RUN cycle
      repeat (2) @(posedge clk);
      issue(12'o3333, 12'o3330);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_outs", 32'({busy, done, lt, et, gt}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) stray = 1'b1;
      end
      chk("midreset_no_done", 32'(stray), 32'd0);
      run_cmp("after_reset", 12'o3333, 12'o3330, 3'b001, 4);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
